// File: rtl/lfsr_stream_packer.sv
// lfsr_stream_packer
// Packs the serial output bit of the LFSR chain MSB-first into WIDTH-bit
// words, queues completed words in a DEPTH-entry FIFO and drains them over a
// valid/ready handshake. Counts accepted words and flags dropped words.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   d, d_en     serial data bit and its sample qualifier
//   flush       push the partial word now (unfilled bits 0)
//   word_out    FIFO head, valid while word_valid = 1
//   word_valid  FIFO non-empty
//   word_ready  consumer accepts head this cycle
//   fill_level  FIFO occupancy, 0..DEPTH
//   word_count  words accepted into the FIFO, wraps at 16 bits
//   overflow    sticky: a word was dropped because the FIFO was full
//   sig         16-bit serial CRC (poly 0x1021), only with LFSR_PACK_SIG_EN
//
// Build option: define LFSR_PACK_SIG_EN to add the sig port and CRC logic.
module lfsr_stream_packer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     d,
  input  logic                     d_en,
  input  logic                     flush,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [15:0]              word_count,
  output logic                     overflow
`ifdef LFSR_PACK_SIG_EN
  ,
  output logic [15:0]              sig
`endif
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  // Pointer XOR pattern meaning "full": wrap bits differ, address bits equal
  localparam logic [PW-1:0] FULL_XOR = PW'(DEPTH);

  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sreg;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [15:0]      r_word_count;
  logic             r_overflow;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [IW-1:0]    w_pos;
  logic [WIDTH-1:0] w_word;
  logic             w_complete;
  logic             w_flush;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_accept;

  // Assembled word including the current bit (if sampled)
  always_comb begin
    w_word = r_sreg;
    w_pos  = IW'(WIDTH - 1) - r_idx;
    if (d_en) begin
      w_word[w_pos] = d;
    end
  end

  assign w_complete = d_en && (r_idx == IW'(WIDTH - 1));
  assign w_flush    = flush && ((r_idx != '0) || d_en);
  assign w_push     = w_complete || w_flush;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = ((r_wr_ptr ^ r_rd_ptr) == FULL_XOR);
  assign w_pop    = !w_empty && word_ready;
  // A full FIFO can still take a word when the head leaves in the same cycle
  assign w_accept = w_push && (!w_full || w_pop);

  // Bit assembly
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx  <= '0;
      r_sreg <= '0;
    end else if (w_push) begin
      r_idx  <= '0;
      r_sreg <= '0;
    end else if (d_en) begin
      r_idx  <= r_idx + IW'(1);
      r_sreg <= w_word;
    end
  end

  // FIFO pointers, word counter and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr     <= r_wr_ptr + PW'(1);
        r_word_count <= r_word_count + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_accept) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FIFO storage, no reset needed: contents are only visible when valid
  always_ff @(posedge clk) begin
    if (!reset && w_accept) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_word;
    end
  end

  assign word_out   = r_mem[r_rd_ptr[AW-1:0]];
  assign word_valid = !w_empty;
  assign fill_level = r_wr_ptr - r_rd_ptr;
  assign word_count = r_word_count;
  assign overflow   = r_overflow;

`ifdef LFSR_PACK_SIG_EN
  logic [15:0] r_sig;
  logic        w_fb;

  assign w_fb = r_sig[15] ^ d;

  // Serial CRC-16 over every sampled bit, independent of FIFO and flush
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sig <= 16'hFFFF;
    end else if (d_en) begin
      r_sig <= {r_sig[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
    end
  end

  assign sig = r_sig;
`endif

endmodule

// File: tb/tb_lfsr_stream_packer.sv
// Testbench for lfsr_stream_packer (WIDTH=32, DEPTH=4).
// Table of word-level steps with hand-computed expected outputs, plus
// directed sequences for full-with-pop, reset mid-word and the signature.
module tb_lfsr_stream_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        d;
  logic        d_en;
  logic        flush;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  fill_level;
  logic [15:0] word_count;
  logic        overflow;
`ifdef LFSR_PACK_SIG_EN
  logic [15:0] sig;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  lfsr_stream_packer #(.WIDTH(32), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .d_en       (d_en),
    .flush      (flush),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .fill_level (fill_level),
    .word_count (word_count),
    .overflow   (overflow)
`ifdef LFSR_PACK_SIG_EN
    ,
    .sig        (sig)
`endif
  );

  always #5 clk = ~clk;

  // fmode: 0 = none, 1 = flush in a separate cycle, 2 = flush with last bit
  typedef struct {
    logic        ready;
    logic [31:0] data;
    int          nbits;
    int          fmode;
    logic        ev;
    logic [31:0] eo;
    int          ef;
    int          ec;
    logic        eovf;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input logic b, input logic en, input logic fl);
    d     = b;
    d_en  = en;
    flush = fl;
    @(posedge clk);
    #1;
    d_en  = 1'b0;
    flush = 1'b0;
    d     = 1'b0;
  endtask

  task automatic feed_bits(input logic [31:0] data, input int nbits, input logic fl_last);
    for (int i = 0; i < nbits; i++) begin
      step(data[31-i], 1'b1, fl_last && (i == nbits - 1));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic ev, input logic [31:0] eo,
                           input int ef, input int ec, input logic eovf);
    chk({tag, ".valid"}, 32'(word_valid), 32'(ev));
    if (ev) chk({tag, ".out"}, word_out, eo);
    chk({tag, ".fill"}, 32'(fill_level), 32'(ef));
    chk({tag, ".count"}, 32'(word_count), 32'(ec));
    chk({tag, ".ovf"}, 32'(overflow), 32'(eovf));
  endtask

  initial begin
    reset = 1'b1; d = 1'b0; d_en = 1'b0; flush = 1'b0; word_ready = 1'b0;

    //          ready  data          nb fm  ev    eo            ef ec ovf
    tbl[0]  = '{1'b1, 32'hA5A50F0F, 32, 0, 1'b1, 32'hA5A50F0F, 1, 1, 1'b0};
    tbl[1]  = '{1'b1, 32'h00000000,  0, 0, 1'b0, 32'h00000000, 0, 1, 1'b0};
    tbl[2]  = '{1'b0, 32'h12345678, 32, 0, 1'b1, 32'h12345678, 1, 2, 1'b0};
    tbl[3]  = '{1'b0, 32'hDEADBEEF, 32, 0, 1'b1, 32'h12345678, 2, 3, 1'b0};
    tbl[4]  = '{1'b0, 32'h0000FFFF, 32, 0, 1'b1, 32'h12345678, 3, 4, 1'b0};
    tbl[5]  = '{1'b0, 32'h80000001, 32, 0, 1'b1, 32'h12345678, 4, 5, 1'b0};
    tbl[6]  = '{1'b0, 32'hCAFEBABE, 32, 0, 1'b1, 32'h12345678, 4, 5, 1'b1};
    tbl[7]  = '{1'b1, 32'h00000000,  0, 0, 1'b1, 32'hDEADBEEF, 3, 5, 1'b1};
    tbl[8]  = '{1'b1, 32'h00000000,  0, 0, 1'b1, 32'h0000FFFF, 2, 5, 1'b1};
    tbl[9]  = '{1'b1, 32'h00000000,  0, 0, 1'b1, 32'h80000001, 1, 5, 1'b1};
    tbl[10] = '{1'b1, 32'h00000000,  0, 0, 1'b0, 32'h00000000, 0, 5, 1'b1};
    tbl[11] = '{1'b0, 32'hA0000000,  3, 1, 1'b1, 32'hA0000000, 1, 6, 1'b1};
    tbl[12] = '{1'b0, 32'h5A5A5A5A, 32, 0, 1'b1, 32'hA0000000, 2, 7, 1'b1};
    tbl[13] = '{1'b1, 32'h00000000,  0, 0, 1'b1, 32'h5A5A5A5A, 1, 7, 1'b1};
    tbl[14] = '{1'b1, 32'h00000000,  0, 0, 1'b0, 32'h00000000, 0, 7, 1'b1};
    tbl[15] = '{1'b0, 32'hC0000000,  2, 2, 1'b1, 32'hC0000000, 1, 8, 1'b1};
    tbl[16] = '{1'b0, 32'h00000000,  0, 1, 1'b1, 32'hC0000000, 1, 8, 1'b1};
    tbl[17] = '{1'b1, 32'h00000000,  0, 0, 1'b0, 32'h00000000, 0, 8, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk_state("reset", 1'b0, 32'h0, 0, 0, 1'b0);

    for (int r = 0; r < 18; r++) begin
      word_ready = tbl[r].ready;
      feed_bits(tbl[r].data, tbl[r].nbits, tbl[r].fmode == 2);
      if (tbl[r].fmode == 1) step(1'b0, 1'b0, 1'b1);
      if (tbl[r].nbits == 0 && tbl[r].fmode == 0) step(1'b0, 1'b0, 1'b0);
      chk_state($sformatf("row%0d", r), tbl[r].ev, tbl[r].eo, tbl[r].ef, tbl[r].ec, tbl[r].eovf);
    end

    // Full FIFO, pop and push on the same edge
    do_reset();
    word_ready = 1'b0;
    feed_bits(32'h11111111, 32, 1'b0);
    feed_bits(32'h22222222, 32, 1'b0);
    feed_bits(32'h33333333, 32, 1'b0);
    feed_bits(32'h44444444, 32, 1'b0);
    chk_state("full4", 1'b1, 32'h11111111, 4, 4, 1'b0);
    feed_bits(32'h55555555, 31, 1'b0);
    word_ready = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    chk_state("fullpop", 1'b1, 32'h22222222, 4, 5, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_state("drain3", 1'b1, 32'h33333333, 3, 5, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_state("drain5", 1'b1, 32'h55555555, 1, 5, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_state("drained", 1'b0, 32'h0, 0, 5, 1'b0);

    // Reset mid-word with words queued; inputs in the reset cycle ignored
    word_ready = 1'b0;
    feed_bits(32'h0F0F0F0F, 32, 1'b0);
    feed_bits(32'hF0F0F0F0, 32, 1'b0);
    feed_bits(32'hFFFFFFFF, 10, 1'b0);
    chk_state("prerst", 1'b1, 32'h0F0F0F0F, 2, 7, 1'b0);
    reset = 1'b1; word_ready = 1'b1; d = 1'b1; d_en = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; word_ready = 1'b0; d = 1'b0; d_en = 1'b0; flush = 1'b0;
    chk_state("midrst", 1'b0, 32'h0, 0, 0, 1'b0);
    feed_bits(32'h3C3C1234, 32, 1'b0);
    chk_state("postrst", 1'b1, 32'h3C3C1234, 1, 1, 1'b0);
    word_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk_state("postpop", 1'b0, 32'h0, 0, 1, 1'b0);

`ifdef LFSR_PACK_SIG_EN
    do_reset();
    chk("sig.reset", 32'(sig), 32'h0000FFFF);
    step(1'b0, 1'b1, 1'b0);
    chk("sig.d0", 32'(sig), 32'h0000EFDF);
    step(1'b1, 1'b1, 1'b0);
    chk("sig.d1", 32'(sig), 32'h0000DFBE);
    step(1'b0, 1'b0, 1'b1);
    chk("sig.flush", 32'(sig), 32'h0000DFBE);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
